alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Sequences one UART ALU command after the packet header has been parsed.
- Consumes payload bytes from the RX byte stream and packs them little-endian into 32-bit operands.
- Folds the operands through the shared arithmetic unit (add or mul) with a valid/ready/result handshake.
- Presents the final 32-bit accumulator with a one-cycle done pulse to the UART response path.

Parameters:
- datawidth_p, 8: RX byte width.
- wordwidth_p, 32: operand/accumulator width; must be a multiple of datawidth_p.
- timeout_p, 65535: RX idle-cycle limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle pulse that begins a command
- op_sel_i  in  2  operation, op_sel_e from alu_pkg (OpAdd, OpMul)
- len_i  in  16  total packet length in bytes, including the 4 header bytes; sampled on start_i
- rx_data_i  in  datawidth_p  payload byte
- rx_valid_i  in  1  payload byte valid
- rx_ready_o  out  1  sequencer accepts a byte
- unit_valid_o  out  1  operand pair valid to the arithmetic unit
- unit_ready_i  in  1  arithmetic unit accepts the operand pair
- unit_sel_o  out  2  operation for the unit
- unit_a_o  out  wordwidth_p  accumulator operand
- unit_b_o  out  wordwidth_p  new operand
- unit_res_valid_i  in  1  unit result valid, one-cycle pulse
- unit_res_i  in  wordwidth_p  unit result
- busy_o  out  1  high from start accepted until done
- done_o  out  1  one-cycle completion pulse
- result_o  out  wordwidth_p  final accumulator; held until the next start
- error_o  out  1  one-cycle abort pulse; tied 0 without the optional feature

Behaviour:
- Reset: state Idle. All outputs 0: rx_ready_o, unit_valid_o, busy_o, done_o, error_o, result_o, unit_a_o, unit_b_o, unit_sel_o. Internal byte count, word count and accumulator clear to 0.
- Payload byte count P = len_i - 4. If len_i <= 4, P = 0.
- Idle:
  - start_i latches op_sel_i and P, clears the accumulator, word index and byte lane, and sets busy_o the next cycle.
  - If P == 0: go to Done; result is 0 and no unit transaction occurs.
  - Otherwise go to Collect.
- Collect:
  - rx_ready_o = 1.
  - Each accepted byte (rx_valid_i && rx_ready_o) goes into lane k of the word buffer. Lane 0 is bits [7:0]. k increments, and P decrements.
  - The word closes when lane 3 is filled, or when P reaches 0. On a short final word, unfilled lanes are zero.
  - First word closed: load it into the accumulator directly, with no unit transaction. Stay in Collect if P > 0, else go to Done.
  - Later words: go to Issue. rx_ready_o drops in the cycle after the closing byte is accepted.
- Issue:
  - unit_valid_o = 1, unit_a_o = acc, unit_b_o = word, unit_sel_o = latched op.
  - Operands stay stable until unit_ready_i.
  - On handshake, go to WaitRes.
- WaitRes:
  - unit_valid_o = 0.
  - On unit_res_valid_i, acc <= unit_res_i (truncated to wordwidth_p). Go to Collect if P > 0, else Done.
  - unit_res_valid_i outside WaitRes is ignored.
- Done:
  - For one cycle: done_o = 1 and result_o = acc. busy_o clears the same cycle.
  - Return to Idle.
- start_i while busy_o = 1 is ignored.
- rst_i mid-command aborts immediately to the reset state. Any in-flight unit result is discarded.
- Arithmetic: wrap modulo 2^wordwidth_p. Overflow is not flagged.
- Latency: the last payload byte accepted at cycle t gives done_o at t+1 (single word) or at r+1 (last unit result at cycle r).

Optional Feature:
- ALU_SEQ_TIMEOUT_EN defined:
  - A counter runs in Collect and resets on each accepted byte.
  - When it reaches timeout_p with no byte, pulse error_o for one cycle, clear busy_o, leave done_o and result_o unchanged, and go to Idle.
- ALU_SEQ_TIMEOUT_EN undefined:
  - No counter is built, error_o is constant 0, and Collect waits indefinitely.

Decomposition:
- Shared package alu_pkg holds:
  - op_sel_e (OpAdd = 2'd0, OpMul = 2'd1)
  - opcode constants OpcAdd = 8'h10, OpcMul = 8'h11, OpcDiv = 8'h12
  - HdrLen = 4
  - sequencer state enum seq_state_e {SqIdle, SqCollect, SqIssue, SqWaitRes, SqDone}
- One sub-module: alu_word_packer.
  - Handles the byte-lane counter, the zero-filled word buffer and the word-closed strobe.
  - Takes a byte valid input and a last-byte flag.

Test Plan:
- Add, len = 12, payload 01 00 00 00 02 00 00 00:
  - expect one unit transaction with a = 1, b = 2.
  - Respond 3: done_o pulse, result_o = 32'h3.
- Mul, len = 16, words 3, 5, 7, unit responding with a 4-cycle latency:
  - expect two unit transactions, (3, 5) then (15, 7).
  - result_o = 105, with rx_ready_o low during each Issue/WaitRes.
- Add, len = 10, payload AA BB CC DD 11 22:
  - second word is 32'h00002211, so unit_b_o = 32'h00002211.
  - Result 32'hDDCCBBAA + 32'h2211 = 32'hDDCCDDBB.
- len = 4 and len = 2: done_o one cycle after busy, result_o = 0, no unit_valid_o.
- Backpressure: hold unit_ready_i low for 10 cycles; operands stay stable. A start_i mid-command is ignored. rst_i during WaitRes gives all outputs 0 the next cycle.
- With ALU_SEQ_TIMEOUT_EN and timeout_p = 20: stall RX after 2 bytes; error_o pulses at the 20th idle cycle, busy_o clears, done_o stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the UART ALU command path.
package alu_pkg;

  typedef enum logic [1:0] {
    OpAdd = 2'd0,
    OpMul = 2'd1
  } op_sel_e;

  localparam logic [7:0] OpcAdd = 8'h10;
  localparam logic [7:0] OpcMul = 8'h11;
  localparam logic [7:0] OpcDiv = 8'h12;

  // Header bytes counted in the packet length but not in the payload.
  localparam int HdrLen = 4;

  typedef enum logic [2:0] {
    SqIdle    = 3'd0,
    SqCollect = 3'd1,
    SqIssue   = 3'd2,
    SqWaitRes = 3'd3,
    SqDone    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/alu_word_packer.sv
// Packs RX bytes little-endian into a word; the word closes on the top lane
// or on the last payload byte, with unfilled lanes reading as zero.
module alu_word_packer
  import alu_pkg::*;
#(
  parameter int datawidth_p = 8,
  parameter int wordwidth_p = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   byte_valid,
  input  logic                   last_byte,
  input  logic [datawidth_p-1:0] byte_data,
  output logic [wordwidth_p-1:0] word,
  output logic                   word_closed
);

  localparam int Lanes = wordwidth_p / datawidth_p;
  localparam int LaneW = (Lanes > 1) ? $clog2(Lanes) : 1;

  logic [LaneW-1:0]       lane;
  logic [wordwidth_p-1:0] buffer;

  // Current word with the incoming byte merged in; lanes above it are zero,
  // so a fresh word never carries bytes from the previous one.
  always_comb begin
    word = '0;
    for (int i = 0; i < Lanes; i++) begin
      if (i < int'(lane)) begin
        word[i*datawidth_p +: datawidth_p] = buffer[i*datawidth_p +: datawidth_p];
      end else if (i == int'(lane)) begin
        word[i*datawidth_p +: datawidth_p] = byte_data;
      end
    end
  end

  assign word_closed = byte_valid && (last_byte || (lane == LaneW'(Lanes - 1)));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane   <= '0;
      buffer <= '0;
    end else if (byte_valid) begin
      buffer <= word;
      lane   <= word_closed ? '0 : lane + LaneW'(1);
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU command: collects payload words and folds them through the
// shared add/mul unit. Optional RX idle timeout under ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int datawidth_p = 8,
  parameter int wordwidth_p = 32,
  parameter int timeout_p   = 65535
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [1:0]             op_sel_i,
  input  logic [15:0]            len_i,
  input  logic [datawidth_p-1:0] rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  output logic                   unit_valid_o,
  input  logic                   unit_ready_i,
  output logic [1:0]             unit_sel_o,
  output logic [wordwidth_p-1:0] unit_a_o,
  output logic [wordwidth_p-1:0] unit_b_o,
  input  logic                   unit_res_valid_i,
  input  logic [wordwidth_p-1:0] unit_res_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [wordwidth_p-1:0] result_o,
  output logic                   error_o
);

  seq_state_e             state;
  logic [1:0]             op_q;
  logic [15:0]            remain;
  logic                   first_word;
  logic [wordwidth_p-1:0] acc;

  logic                   accept;
  logic                   last_byte;
  logic                   pk_clear;
  logic                   word_closed;
  logic [wordwidth_p-1:0] word;
  logic [15:0]            payload_len;

  // Handshake: a byte transfers on a cycle with rx_valid_i && rx_ready_o;
  // an operand pair transfers on unit_valid_o && unit_ready_i; results are
  // single-cycle unit_res_valid_i pulses taken only while waiting for one.
  assign accept      = rx_valid_i && rx_ready_o;
  assign last_byte   = (remain == 16'd1);
  assign pk_clear    = (state == SqIdle) && start_i;
  assign payload_len = (len_i <= 16'(HdrLen)) ? 16'd0 : len_i - 16'(HdrLen);

  alu_word_packer #(
    .datawidth_p(datawidth_p),
    .wordwidth_p(wordwidth_p)
  ) u_packer (
    .clk        (clk_i),
    .rst        (rst_i),
    .clear      (pk_clear),
    .byte_valid (accept),
    .last_byte  (last_byte),
    .byte_data  (rx_data_i),
    .word       (word),
    .word_closed(word_closed)
  );

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TmoW = $clog2(timeout_p + 1);
  logic [TmoW-1:0] idle_cnt;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= SqIdle;
      op_q         <= 2'd0;
      remain       <= 16'd0;
      first_word   <= 1'b0;
      acc          <= '0;
      rx_ready_o   <= 1'b0;
      unit_valid_o <= 1'b0;
      unit_sel_o   <= 2'd0;
      unit_a_o     <= '0;
      unit_b_o     <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      result_o     <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
      error_o      <= 1'b0;
      idle_cnt     <= '0;
`endif
    end else begin
      done_o <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      error_o <= 1'b0;
`endif
      case (state)
        SqIdle: begin
          if (start_i) begin
            op_q       <= op_sel_i;
            remain     <= payload_len;
            acc        <= '0;
            first_word <= 1'b1;
            busy_o     <= 1'b1;
`ifdef ALU_SEQ_TIMEOUT_EN
            idle_cnt   <= '0;
`endif
            if (payload_len == 16'd0) begin
              state <= SqDone;
            end else begin
              state      <= SqCollect;
              rx_ready_o <= 1'b1;
            end
          end
        end

        SqCollect: begin
          if (accept) begin
            remain <= remain - 16'd1;
`ifdef ALU_SEQ_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (word_closed) begin
              if (first_word) begin
                // The first word seeds the accumulator without a unit transaction.
                first_word <= 1'b0;
                acc        <= word;
                if (last_byte) begin
                  rx_ready_o <= 1'b0;
                  busy_o     <= 1'b0;
                  done_o     <= 1'b1;
                  result_o   <= word;
                  state      <= SqDone;
                end
              end else begin
                rx_ready_o   <= 1'b0;
                unit_valid_o <= 1'b1;
                unit_a_o     <= acc;
                unit_b_o     <= word;
                unit_sel_o   <= op_q;
                state        <= SqIssue;
              end
            end
          end
`ifdef ALU_SEQ_TIMEOUT_EN
          else if (idle_cnt == TmoW'(timeout_p - 1)) begin
            error_o    <= 1'b1;
            busy_o     <= 1'b0;
            rx_ready_o <= 1'b0;
            state      <= SqIdle;
          end else begin
            idle_cnt <= idle_cnt + TmoW'(1);
          end
`endif
        end

        SqIssue: begin
          if (unit_ready_i) begin
            unit_valid_o <= 1'b0;
            state        <= SqWaitRes;
          end
        end

        SqWaitRes: begin
          if (unit_res_valid_i) begin
            acc <= unit_res_i;
            if (remain == 16'd0) begin
              busy_o   <= 1'b0;
              done_o   <= 1'b1;
              result_o <= unit_res_i;
              state    <= SqDone;
            end else begin
              rx_ready_o <= 1'b1;
              state      <= SqCollect;
            end
          end
        end

        SqDone: begin
          // Entered with busy still high only for an empty payload; that path
          // raises done here, every other path raised it on entry.
          if (busy_o) begin
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            result_o <= acc;
          end else begin
            state <= SqIdle;
          end
        end

        default: state <= SqIdle;
      endcase
    end
  end

`ifndef ALU_SEQ_TIMEOUT_EN
  assign error_o = 1'b0;
`endif

endmodule
